// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding, widths and step-shifter codes
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int W = 4;
  localparam int AMT_W = 3;
  localparam int MAX_STEP = 2;
  localparam logic [1:0] STEP_0 = 2'b00;
  localparam logic [1:0] STEP_1 = 2'b01;
  localparam logic [1:0] STEP_2 = 2'b10;
endpackage

// File: rtl/shift_gate.sv
// shift_gate: 4-bit combinational logical shifter by 0/1/2, dir 0=left
module shift_gate (
  input  logic [3:0] a_i,
  input  logic [1:0] amt_i,
  input  logic       dir_i,
  output logic [3:0] y_o
);
  always_comb y_o = dir_i ? (a_i >> amt_i) : (a_i << amt_i);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle logical shifter, up to two bit positions per cycle
module shift_sequencer #(
  parameter int W = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y
);
  import shift_seq_pkg::*;
  state_e state_q, state_d;
  logic [W-1:0] acc_q, acc_d, gate_y;
  logic [AMT_W-1:0] rem_q, rem_d, step, rem_nxt;
  logic dir_q, dir_d;
  logic [1:0] code;
  always_comb begin
    code = (state_q != SHIFT) ? STEP_0 : (rem_q >= AMT_W'(MAX_STEP)) ? STEP_2 : STEP_1;
    step = {{(AMT_W-2){1'b0}}, code};
    rem_nxt = rem_q - step;
  end
  shift_gate u_gate (
    .a_i  (acc_q),
    .amt_i(code),
    .dir_i(dir_q),
    .y_o  (gate_y)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    rem_d = rem_q;
    dir_d = dir_q;
    case (state_q)
      IDLE: if (in_valid) begin
        acc_d = in_a;
        rem_d = in_amt;
        dir_d = in_dir;
        state_d = (in_amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_d = gate_y;
        rem_d = rem_nxt;
        state_d = (rem_nxt == '0) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    out_y = acc_q;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of latency, results, backpressure and reset
module tb_shift_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_dir = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0;
  logic [2:0] in_amt = '0;
  logic in_ready, out_valid;
  logic [3:0] out_y;
  int errors = 0, checks = 0;

  shift_sequencer #(.W(4), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one request, optionally keep in_valid high with junk, then measure latency
  task automatic run(input string tag, input logic [3:0] a, input logic [2:0] amt, input logic dir,
                     input int exp_lat, input logic [3:0] exp_y, input bit hold);
    int n;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    in_valid = 1'b1; in_a = a; in_amt = amt; in_dir = dir;
    @(posedge clk); #1;
    if (hold) begin
      in_a = ~a; in_amt = 3'd1; in_dir = ~dir;
    end else in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_out_y"}, {28'd0, out_y}, {28'd0, exp_y});
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag, input logic [3:0] exp_y);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 0);
    check({tag, "_idle_y"}, {28'd0, out_y}, {28'd0, exp_y});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 1);
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_out_y", {28'd0, out_y}, 0);

    run("amt0", 4'b1011, 3'd0, 1'b0, 1, 4'b1011, 1'b0);
    take("amt0", 4'b1011);
    run("l3", 4'b0011, 3'd3, 1'b0, 3, 4'b1000, 1'b0);
    take("l3", 4'b1000);
    run("l7", 4'b1111, 3'd7, 1'b0, 5, 4'b0000, 1'b0);
    take("l7", 4'b0000);
    run("r1", 4'b1001, 3'd1, 1'b1, 2, 4'b0100, 1'b0);
    take("r1", 4'b0100);
    run("l4", 4'b0110, 3'd4, 1'b0, 3, 4'b0000, 1'b0);
    take("l4", 4'b0000);
    run("r5", 4'b1000, 3'd5, 1'b1, 4, 4'b0000, 1'b0);
    take("r5", 4'b0000);
    run("l3_hold", 4'b0001, 3'd3, 1'b0, 3, 4'b1000, 1'b1);
    take("l3_hold", 4'b1000);

    // Backpressure in DONE with a competing request driven
    run("r2", 4'b1101, 3'd2, 1'b1, 2, 4'b0011, 1'b0);
    in_valid = 1'b1; in_a = 4'b1111; in_amt = 3'd1; in_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_y", {28'd0, out_y}, 32'h3);
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_take_ready", {31'd0, in_ready}, 1);
    check("bp_take_valid", {31'd0, out_valid}, 0);
    check("bp_take_y", {28'd0, out_y}, 32'h3);

    // Reset one cycle after accepting a long shift
    in_valid = 1'b1; in_a = 4'b0001; in_amt = 3'd6; in_dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_y", {28'd0, out_y}, 0);
    run("post_rst", 4'b0101, 3'd1, 1'b1, 2, 4'b0010, 1'b0);
    take("post_rst", 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter W, default 4: operand/result width; only W=4 is supported.
REQ-002 Parameter AMT_W, default 3: total shift-amount width, so shifts of 0..7 are supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on in_a/in_amt/in_dir.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_a  input  W  operand.
REQ-008 in_amt  input  AMT_W  total shift distance.
REQ-009 in_dir  input  1  0 = left (logical), 1 = right (logical).
REQ-010 out_valid  output  1  result available on out_y.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_y  output  W  shifted result.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance (IDLE with in_valid=1 at an edge) SHALL load acc<=in_a, rem<=in_amt, dir<=in_dir, and go to DONE if in_amt=0, else to SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply step = 2 if rem>=2, else 1, through the step shifter to acc, and SHALL set rem<=rem-step.
REQ-017 SHIFT SHALL go to DONE on the edge where rem-step=0, and otherwise stay in SHIFT.
REQ-018 Latency: out_valid SHALL rise 1+ceil(in_amt/2) cycles after the accepting edge (1 cycle when in_amt=0).
REQ-019 Zeros SHALL fill vacated bits; bits shifted past either end SHALL be discarded; in_amt>=4 SHALL give out_y=0 with normal latency.
REQ-020 out_y SHALL equal acc at all times; it SHALL be stable in DONE and hold its last value in IDLE.
REQ-021 DONE with out_ready=1 SHALL go to IDLE; no request SHALL be accepted in that same cycle (in_ready=0 in DONE).
REQ-022 DONE with out_ready=0 SHALL hold state, acc and out_y indefinitely.
REQ-023 in_valid in SHIFT or DONE SHALL be ignored and SHALL NOT change internal state.
REQ-024 Step-shifter amount code 2'b11 SHALL never be driven.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, acc=0, rem=0 and dir=0, giving in_ready=1, out_valid=0 and out_y=0 on the next cycle.
REQ-026 rst SHALL take priority over every handshake and over any operation in progress; an interrupted operation SHALL be abandoned with no result.

Structure
REQ-027 A shared package shift_seq_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), constants W=4, AMT_W=3, MAX_STEP=2, and the 2-bit step-code constants.
REQ-028 The per-cycle shift SHALL be done by exactly one instance of the existing combinational shift_gate (4-bit, amount 0/1/2, dir 0=left).
REQ-029 The FSM, acc, rem and dir registers SHALL live in shift_sequencer; the block SHALL NOT contain any other shift datapath.

Verification
REQ-030 A=1011, amt=0, dir=0 -> out_valid 1 cycle after accept, out_y=1011.
REQ-031 A=0011, amt=3, left -> steps 2 then 1; out_valid 3 cycles after accept; out_y=1000.
REQ-032 A=1101, amt=2, right -> out_valid 2 cycles after accept; out_y=0011.
REQ-033 A=1111, amt=7, left -> out_valid 5 cycles after accept; out_y=0000.
REQ-034 Backpressure: out_ready=0 for 3 cycles in DONE, with in_valid=1 and new data driven -> out_y, out_valid=1 and in_ready=0 all held; the result is taken on the first out_ready=1, then IDLE.
REQ-035 rst=1 mid-SHIFT (A=0001, amt=6, left, asserted 1 cycle after accept) -> next cycle IDLE, out_y=0, out_valid=0; a fresh request then completes normally.
